// File: rtl/vertice_rotator.sv
// Eight-stage pipelined CORDIC rotation of four polygon vertices, followed by
// translation to the reference point and clamping to 10-bit screen space.
module vertice_rotator #(
   parameter int ITER = 8,
   parameter int CW   = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [CW-1:0] in_v1_x,
   input  logic signed [CW-1:0] in_v1_y,
   input  logic signed [CW-1:0] in_v2_x,
   input  logic signed [CW-1:0] in_v2_y,
   input  logic signed [CW-1:0] in_v3_x,
   input  logic signed [CW-1:0] in_v3_y,
   input  logic signed [CW-1:0] in_v4_x,
   input  logic signed [CW-1:0] in_v4_y,
   input  logic signed [8:0]    angle_cordic,
   input  logic                 enable_cordic,
   input  logic [8:0]           ref_point_x,
   input  logic [8:0]           ref_point_y,
   input  logic                 in_form,
   input  logic [8:0]           in_st2_color,
   input  logic [9:0]           in_st2_pixel_x,
   input  logic [9:0]           in_st2_pixel_y,
   input  logic                 in_st2_bubble,
   output logic [9:0]           v1_x,
   output logic [9:0]           v1_y,
   output logic [9:0]           v2_x,
   output logic [9:0]           v2_y,
   output logic [9:0]           v3_x,
   output logic [9:0]           v3_y,
   output logic [9:0]           v4_x,
   output logic [9:0]           v4_y,
   output logic                 out_form,
   output logic [8:0]           out_st2_color,
   output logic [9:0]           out_st2_pixel_x,
   output logic [9:0]           out_st2_pixel_y,
   output logic                 out_st2_bubble
);

   // atan(2^-i) in units of 90/128 degrees
   localparam logic signed [8:0] ATAN [0:7] = '{9'sd64, 9'sd38, 9'sd20, 9'sd10,
                                               9'sd5,  9'sd3,  9'sd1,  9'sd1};

   logic signed [CW-1:0] w_vx [4];
   logic signed [CW-1:0] w_vy [4];

   assign w_vx[0] = in_v1_x;
   assign w_vx[1] = in_v2_x;
   assign w_vx[2] = in_v3_x;
   assign w_vx[3] = in_v4_x;
   assign w_vy[0] = in_v1_y;
   assign w_vy[1] = in_v2_y;
   assign w_vy[2] = in_v3_y;
   assign w_vy[3] = in_v4_y;

   logic [8:0] r_sb_rx    [ITER];
   logic [8:0] r_sb_ry    [ITER];
   logic       r_sb_en    [ITER];
   logic       r_sb_form  [ITER];
   logic [8:0] r_sb_color [ITER];
   logic [9:0] r_sb_px    [ITER];
   logic [9:0] r_sb_py    [ITER];
   logic       r_sb_bub   [ITER];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < ITER; k++) begin
            r_sb_rx[k]    <= '0;
            r_sb_ry[k]    <= '0;
            r_sb_en[k]    <= 1'b0;
            r_sb_form[k]  <= 1'b0;
            r_sb_color[k] <= '0;
            r_sb_px[k]    <= '0;
            r_sb_py[k]    <= '0;
            r_sb_bub[k]   <= 1'b0;
         end
      end else begin
         r_sb_rx[0]    <= ref_point_x;
         r_sb_ry[0]    <= ref_point_y;
         r_sb_en[0]    <= enable_cordic;
         r_sb_form[0]  <= in_form;
         r_sb_color[0] <= in_st2_color;
         r_sb_px[0]    <= in_st2_pixel_x;
         r_sb_py[0]    <= in_st2_pixel_y;
         r_sb_bub[0]   <= in_st2_bubble;
         for (int k = 1; k < ITER; k++) begin
            r_sb_rx[k]    <= r_sb_rx[k-1];
            r_sb_ry[k]    <= r_sb_ry[k-1];
            r_sb_en[k]    <= r_sb_en[k-1];
            r_sb_form[k]  <= r_sb_form[k-1];
            r_sb_color[k] <= r_sb_color[k-1];
            r_sb_px[k]    <= r_sb_px[k-1];
            r_sb_py[k]    <= r_sb_py[k-1];
            r_sb_bub[k]   <= r_sb_bub[k-1];
         end
      end
   end

   for (genvar gi = 0; gi < ITER; gi++) begin : g_stage
      logic signed [CW-1:0] w_xi [4];
      logic signed [CW-1:0] w_yi [4];
      logic signed [8:0]    w_zi;
      logic                 w_en;
      logic signed [CW-1:0] r_x [4];
      logic signed [CW-1:0] r_y [4];

      if (gi == 0) begin : g_src
         assign w_xi = w_vx;
         assign w_yi = w_vy;
         assign w_zi = angle_cordic;
         assign w_en = enable_cordic;
      end else begin : g_src
         assign w_xi = g_stage[gi-1].r_x;
         assign w_yi = g_stage[gi-1].r_y;
         assign w_zi = g_stage[gi-1].g_z.r_z;
         assign w_en = r_sb_en[gi-1];
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int v = 0; v < 4; v++) begin
               r_x[v] <= '0;
               r_y[v] <= '0;
            end
         end else begin
            for (int v = 0; v < 4; v++) begin
               if (!w_en) begin
                  r_x[v] <= w_xi[v];
                  r_y[v] <= w_yi[v];
               end else if (!w_zi[8]) begin
                  r_x[v] <= w_xi[v] - (w_yi[v] >>> gi);
                  r_y[v] <= w_yi[v] + (w_xi[v] >>> gi);
               end else begin
                  r_x[v] <= w_xi[v] + (w_yi[v] >>> gi);
                  r_y[v] <= w_yi[v] - (w_xi[v] >>> gi);
               end
            end
         end
      end

      // the residual angle leaving the final stage has no consumer
      if (gi < ITER-1) begin : g_z
         logic signed [8:0] r_z;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) r_z <= '0;
            else        r_z <= w_zi[8] ? (w_zi + ATAN[gi]) : (w_zi - ATAN[gi]);
         end
      end
   end

   function automatic logic signed [CW-1:0] gain_comp(input logic signed [CW-1:0] x);
      return x + (x >>> 1) + (x >>> 3) + (x >>> 6) + (x >>> 8) + (x >>> 9);
   endfunction

   function automatic logic [9:0] clamp_scr(input logic [8:0] rp, input logic signed [CW-1:0] c);
      logic signed [CW-1:0] s;
      s = $signed({{(CW-9){1'b0}}, rp}) + c;
      if (s < 0)                    return 10'd0;
      else if (s > $signed(CW'(1023))) return 10'd1023;
      else                          return s[9:0];
   endfunction

   logic [9:0] r_ox [4];
   logic [9:0] r_oy [4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int v = 0; v < 4; v++) begin
            r_ox[v] <= '0;
            r_oy[v] <= '0;
         end
         out_form        <= 1'b0;
         out_st2_color   <= '0;
         out_st2_pixel_x <= '0;
         out_st2_pixel_y <= '0;
         out_st2_bubble  <= 1'b0;
      end else begin
         for (int v = 0; v < 4; v++) begin
            r_ox[v] <= clamp_scr(r_sb_rx[ITER-1], r_sb_en[ITER-1] ? g_stage[ITER-1].r_x[v]
                                                  : gain_comp(g_stage[ITER-1].r_x[v]));
            r_oy[v] <= clamp_scr(r_sb_ry[ITER-1], r_sb_en[ITER-1] ? g_stage[ITER-1].r_y[v]
                                                  : gain_comp(g_stage[ITER-1].r_y[v]));
         end
         out_form        <= r_sb_form[ITER-1];
         out_st2_color   <= r_sb_color[ITER-1];
         out_st2_pixel_x <= r_sb_px[ITER-1];
         out_st2_pixel_y <= r_sb_py[ITER-1];
         out_st2_bubble  <= r_sb_bub[ITER-1];
      end
   end

   assign v1_x = r_ox[0];
   assign v1_y = r_oy[0];
   assign v2_x = r_ox[1];
   assign v2_y = r_oy[1];
   assign v3_x = r_ox[2];
   assign v3_y = r_oy[2];
   assign v4_x = r_ox[3];
   assign v4_y = r_oy[3];

endmodule

// File: tb/tb_vertice_rotator.sv
// Directed and streaming checks for vertice_rotator: bypass gain, 45-degree
// rotation, clamping, triangle v4, async reset and sideband alignment.
module tb_vertice_rotator;

   logic               clk;
   logic               reset;
   logic signed [18:0] in_v1_x, in_v1_y, in_v2_x, in_v2_y;
   logic signed [18:0] in_v3_x, in_v3_y, in_v4_x, in_v4_y;
   logic signed [8:0]  angle_cordic;
   logic               enable_cordic;
   logic [8:0]         ref_point_x, ref_point_y;
   logic               in_form;
   logic [8:0]         in_st2_color;
   logic [9:0]         in_st2_pixel_x, in_st2_pixel_y;
   logic               in_st2_bubble;
   logic [9:0]         v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y;
   logic               out_form;
   logic [8:0]         out_st2_color;
   logic [9:0]         out_st2_pixel_x, out_st2_pixel_y;
   logic               out_st2_bubble;

   int n_chk  = 0;
   int n_fail = 0;

   vertice_rotator u_dut (
      .clk(clk), .reset(reset),
      .in_v1_x(in_v1_x), .in_v1_y(in_v1_y), .in_v2_x(in_v2_x), .in_v2_y(in_v2_y),
      .in_v3_x(in_v3_x), .in_v3_y(in_v3_y), .in_v4_x(in_v4_x), .in_v4_y(in_v4_y),
      .angle_cordic(angle_cordic), .enable_cordic(enable_cordic),
      .ref_point_x(ref_point_x), .ref_point_y(ref_point_y), .in_form(in_form),
      .in_st2_color(in_st2_color), .in_st2_pixel_x(in_st2_pixel_x),
      .in_st2_pixel_y(in_st2_pixel_y), .in_st2_bubble(in_st2_bubble),
      .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
      .v3_x(v3_x), .v3_y(v3_y), .v4_x(v4_x), .v4_y(v4_y),
      .out_form(out_form), .out_st2_color(out_st2_color),
      .out_st2_pixel_x(out_st2_pixel_x), .out_st2_pixel_y(out_st2_pixel_y),
      .out_st2_bubble(out_st2_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp, input int tol);
      n_chk++;
      if (obs > exp + tol || obs < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic clr_in();
      in_v1_x = 0; in_v1_y = 0; in_v2_x = 0; in_v2_y = 0;
      in_v3_x = 0; in_v3_y = 0; in_v4_x = 0; in_v4_y = 0;
      angle_cordic = 0; enable_cordic = 0; ref_point_x = 0; ref_point_y = 0;
      in_form = 0; in_st2_color = 0; in_st2_pixel_x = 0; in_st2_pixel_y = 0;
      in_st2_bubble = 0;
   endtask

   task automatic wait_lat();
      repeat (9) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int gain_m(input int x);
      return x + (x >>> 1) + (x >>> 3) + (x >>> 6) + (x >>> 8) + (x >>> 9);
   endfunction

   function automatic int clamp_m(input int s);
      return (s < 0) ? 0 : (s > 1023) ? 1023 : s;
   endfunction

   // reference: one vertex through the rotation, gain and screen mapping
   function automatic void mdl(input int x0, input int y0, input int ang, input bit en,
                               input int rx, input int ry, output int ox, output int oy);
      int at [8] = '{64, 38, 20, 10, 5, 3, 1, 1};
      int x, y, z, xn, yn;
      x = x0; y = y0; z = ang;
      for (int i = 0; i < 8; i++) begin
         if (en) begin
            if (z >= 0) begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - at[i]; end
            else        begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + at[i]; end
            x = xn; y = yn;
         end
      end
      if (!en) begin x = gain_m(x); y = gain_m(y); end
      ox = clamp_m(rx + x);
      oy = clamp_m(ry + y);
   endfunction

   int ex_x [20], ex_y [20], ex_c [20], ex_px [20], ex_py [20], ex_b [20];

   initial begin
      int ox, oy, vx, vy, ang, rx, ry;
      clr_in();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_v1_x", v1_x, 0, 0);
      chk("rst_v4_y", v4_y, 0, 0);
      chk("rst_bubble", out_st2_bubble, 0, 0);
      reset = 1'b1;

      // bypass with gain compensation
      clr_in();
      ref_point_x = 100; ref_point_y = 100;
      in_v1_x = -38; in_v1_y = -38; in_v3_x = 38; in_v3_y = 38;
      wait_lat();
      chk("byp_v1_x", v1_x, 35, 0);
      chk("byp_v1_y", v1_y, 35, 0);
      chk("byp_v3_x", v3_x, 161, 0);
      chk("byp_v3_y", v3_y, 161, 0);
      chk("byp_v2_x", v2_x, 100, 0);

      // rotate 45 degrees
      clr_in();
      enable_cordic = 1; angle_cordic = 64; ref_point_x = 200; ref_point_y = 150;
      in_v1_x = 38;
      wait_lat();
      chk("rot_v1_x", v1_x, 244, 2);
      chk("rot_v1_y", v1_y, 194, 2);
      chk("rot_v2_x", v2_x, 200, 0);
      chk("rot_v2_y", v2_y, 150, 0);
      chk("rot_v4_x", v4_x, 200, 0);
      chk("rot_v4_y", v4_y, 150, 0);

      // clamp high and low
      clr_in();
      ref_point_x = 511; ref_point_y = 511;
      in_v1_x = 500; in_v1_y = 500; in_v2_x = -400; in_v2_y = -400;
      wait_lat();
      chk("clp_v1_x", v1_x, 1023, 0);
      chk("clp_v1_y", v1_y, 1023, 0);
      chk("clp_v2_x", v2_x, 0, 0);
      chk("clp_v2_y", v2_y, 0, 0);

      // triangle: v4 stays on the reference point
      clr_in();
      in_form = 1; enable_cordic = 1; angle_cordic = -100;
      ref_point_x = 300; ref_point_y = 200; in_v1_x = 50; in_st2_color = 9'h155;
      wait_lat();
      chk("tri_form", out_form, 1, 0);
      chk("tri_v4_x", v4_x, 300, 0);
      chk("tri_v4_y", v4_y, 200, 0);
      chk("tri_color", out_st2_color, 9'h155, 0);

      // async reset mid-stream, then exact latency after release
      clr_in();
      ref_point_x = 100; ref_point_y = 100; in_v1_x = 38; in_v1_y = 38;
      in_st2_color = 9'h0aa; in_st2_bubble = 1;
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_v1_x", v1_x, 0, 0);
      chk("arst_v1_y", v1_y, 0, 0);
      chk("arst_color", out_st2_color, 0, 0);
      chk("arst_bubble", out_st2_bubble, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("lat8_v1_x", v1_x, 0, 0);
      chk("lat8_color", out_st2_color, 0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat9_v1_x", v1_x, 161, 0);
      chk("lat9_color", out_st2_color, 9'h0aa, 0);
      chk("lat9_bubble", out_st2_bubble, 1, 0);

      // streaming: back-to-back random angles, sideband must stay aligned
      for (int t = 0; t < 29; t++) begin
         if (t >= 9) begin
            chk($sformatf("str%0d_v1_x", t-9), v1_x, ex_x[t-9], 2);
            chk($sformatf("str%0d_v1_y", t-9), v1_y, ex_y[t-9], 2);
            chk($sformatf("str%0d_color", t-9), out_st2_color, ex_c[t-9], 0);
            chk($sformatf("str%0d_px", t-9), out_st2_pixel_x, ex_px[t-9], 0);
            chk($sformatf("str%0d_py", t-9), out_st2_pixel_y, ex_py[t-9], 0);
            chk($sformatf("str%0d_bub", t-9), out_st2_bubble, ex_b[t-9], 0);
         end
         if (t < 20) begin
            vx  = int'($urandom_range(600)) - 300;
            vy  = int'($urandom_range(600)) - 300;
            ang = int'($urandom_range(254)) - 127;
            rx  = int'($urandom_range(511));
            ry  = int'($urandom_range(511));
            clr_in();
            enable_cordic = 1; angle_cordic = 9'(ang);
            in_v1_x = 19'(vx); in_v1_y = 19'(vy);
            ref_point_x = 9'(rx); ref_point_y = 9'(ry);
            in_st2_color = 9'(t + 1); in_st2_pixel_x = 10'(t + 5);
            in_st2_pixel_y = 10'(2 * t); in_st2_bubble = t[0];
            mdl(vx, vy, ang, 1'b1, rx, ry, ox, oy);
            ex_x[t] = ox; ex_y[t] = oy; ex_c[t] = t + 1;
            ex_px[t] = t + 5; ex_py[t] = 2 * t; ex_b[t] = t % 2;
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
